imm_mov_sequencer: RTL and testbench
====================================

// Module: imm_mov_sequencer
// PURPOSE
//  Encoder-side counterpart of the immediate extender.
//  Takes a 64-bit constant and a destination register, then emits the shortest MOVZ/MOVK
//  instruction sequence (IM format) that materialises the constant.
//  Sits between the test/program generator and instruction memory load.
//  Every emitted word must decode back to the original constant through the MOVZ/MOVK path.
// PARAMETERS
//  MOVZ_OPC   9'b110100101  opcode placed in instr[31:23] for the first instruction
//  MOVK_OPC   9'b111100101  opcode placed in instr[31:23] for follow-on instructions
//  SKIP_ZERO  1             1: omit all-zero halfwords; 0: always emit 4 instrs (hw0..hw3)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   in_value/in_rd valid
//  in_ready   out  1   block can accept a constant (high only in IDLE)
//  in_value   in   64  constant to materialise
//  in_rd      in   5   destination register, copied to instr[4:0]
//  out_valid  out  1   out_instr valid
//  out_ready  in   1   consumer accepts out_instr
//  out_instr  out  32  {opc[8:0], hw[1:0], imm16[15:0], rd[4:0]}
//  out_last   out  1   qualifies final instruction of the sequence
//  busy       out  1   high in EMIT
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; out_valid=0, out_instr=0, out_last=0, busy=0, in_ready=1.
//  FSM states:
//   - IDLE: in_ready=1. On in_valid, latch value, rd, and mask m[3:0].
//     m[i] = (value[16i+15:16i]!=0), or 4'hF if SKIP_ZERO=0. Go to EMIT.
//   - EMIT: in_ready=0, busy=1. Registered outputs; first out_valid appears the cycle after acceptance.
//  Halfword selection:
//   - hw = lowest set bit of the remaining mask.
//   - First instruction uses MOVZ_OPC; all later ones use MOVK_OPC.
//   - Ascending hw order.
//   - If m==0 (value 0): emit a single MOVZ hw=0 imm=0 with out_last=1.
//  Handshake:
//   - out_instr/out_last are held stable while out_valid & !out_ready.
//   - On out_valid & out_ready: clear the emitted bit and present the next word the following cycle (no bubble).
//   - After the handshake with out_last=1, return to IDLE.
//  Throughput and latency:
//   - out_last=1 exactly when the remaining mask has one bit set (or m==0).
//   - A constant of n instrs occupies n+1 cycles min (1 accept + n emit).
//   - First-instruction latency: 1 cycle.
//  Encoding: imm16 = value[16*hw+15:16*hw]; no sign handling (MOVN is not generated).
//  Boundary conditions:
//   - in_valid while busy is ignored; in_ready=0 and input is not latched.
//   - Async reset mid-sequence drops the remaining instrs; outputs return to reset values immediately.
//   - Count of emitted instrs is 1..4 for SKIP_ZERO=1, and exactly 4 for SKIP_ZERO=0.
//  Ignored for this block:
//   - in_value bits are not range-checked (any 64-bit value is legal).
//   - in_rd=31 is legal.
// TESTING
//  1. value=0, rd=1 -> single word 0xD2800001, out_last=1; in_ready returns high 1 cycle after.
//  2. value=0x0000_1234_0000_5678, rd=2, out_ready=1 -> 0xD28ACF02, then 0xF2C24682 (last).
//  3. value=0xABCD_0000_0000_0000, rd=31 -> single 0xD2F579BF (MOVZ hw=3), last=1.
//  4. value=0x1111_2222_3333_4444, out_ready held low 3 cycles per word:
//     -> 4 words (hw0..3, MOVZ then MOVK x3); out_instr stable while stalled; in_valid ignored while busy.
//  5. rst pulsed (async, between edges) after 2nd handshake of test 4:
//     -> out_valid=0 immediately, in_ready=1; next constant encodes from MOVZ.
//  6. SKIP_ZERO=0, value=0x5678, rd=3:
//     -> 0xD28ACF03, 0xF2A00003, 0xF2C00003, 0xF2E00003 (last).

Source files
------------

// File: rtl/imm_mov_sequencer.sv
// ---------------------------------------------------------------------------
// imm_mov_sequencer
//   Turns a 64-bit constant plus a destination register into the shortest
//   MOVZ/MOVK instruction sequence that rebuilds that constant. The first
//   word is always a MOVZ. Each later word is a MOVK. Halfwords are emitted
//   in ascending order. Each emitted word decodes back to its halfword of
//   the constant through the MOVZ/MOVK path.
//
//   Ports
//     clk        in   1   clock, rising edge
//     rst        in   1   asynchronous active-high reset
//     in_valid   in   1   in_value/in_rd valid
//     in_ready   out  1   block can accept a constant (IDLE only)
//     in_value   in   64  constant to materialise
//     in_rd      in   5   destination register -> instr[4:0]
//     out_valid  out  1   out_instr valid
//     out_ready  in   1   consumer accepts out_instr
//     out_instr  out  32  {opc[8:0], hw[1:0], imm16[15:0], rd[4:0]}
//     out_last   out  1   final instruction of the sequence
//     busy       out  1   sequence in progress
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a constant, in_ready=1
//   EMIT  | presenting words, one per accepted handshake, busy=1
// ---------------------------------------------------------------------------
module imm_mov_sequencer #(
    parameter logic [8:0] MOVZ_OPC  = 9'b110100101,
    parameter logic [8:0] MOVK_OPC  = 9'b111100101,
    parameter bit         SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_value,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state;
    logic [63:0] value_q;
    logic [4:0]  rd_q;
    logic [3:0]  mask_q;     // halfwords still to be emitted, including the one on out_instr

    logic [3:0]  in_mask;
    logic [3:0]  accept_mask;
    logic [3:0]  next_mask;

    // Lowest pending halfword. An empty mask maps to hw0, which gives the
    // single "MOVZ hw=0 imm=0" used for a zero constant.
    function automatic logic [1:0] low_hw(input logic [3:0] m);
        logic [1:0] hw;
        if (m[0])      hw = 2'd0;
        else if (m[1]) hw = 2'd1;
        else if (m[2]) hw = 2'd2;
        else if (m[3]) hw = 2'd3;
        else           hw = 2'd0;
        return hw;
    endfunction

    function automatic logic [31:0] encode(input logic [8:0]  opc,
                                           input logic [63:0] value,
                                           input logic [4:0]  rd,
                                           input logic [3:0]  m);
        logic [1:0] hw;
        hw = low_hw(m);
        return {opc, hw, value[{hw, 4'b0000} +: 16], rd};
    endfunction

    // True when at most one bit is set. The word on the output is then the last one.
    function automatic logic single(input logic [3:0] m);
        return (m & (m - 4'd1)) == 4'd0;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_mask[i] = (in_value[16*i +: 16] != 16'h0000);
        end
        accept_mask = SKIP_ZERO ? in_mask : 4'hF;
        next_mask   = mask_q & (mask_q - 4'd1);   // drop the word just handed over
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state == EMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            value_q   <= '0;
            rd_q      <= '0;
            mask_q    <= '0;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        value_q   <= in_value;
                        rd_q      <= in_rd;
                        mask_q    <= accept_mask;
                        // The first word is built straight from the inputs.
                        // This gives one cycle of latency to the first out_valid.
                        out_valid <= 1'b1;
                        out_instr <= encode(MOVZ_OPC, in_value, in_rd, accept_mask);
                        out_last  <= single(accept_mask);
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_instr <= '0;
                            out_last  <= 1'b0;
                            mask_q    <= '0;
                            state     <= IDLE;
                        end else begin
                            mask_q    <= next_mask;
                            out_instr <= encode(MOVK_OPC, value_q, rd_q, next_mask);
                            out_last  <= single(next_mask);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_mov_sequencer.sv
module tb_imm_mov_sequencer;

    localparam logic [8:0] MOVZ = 9'b110100101;
    localparam logic [8:0] MOVK = 9'b111100101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A: SKIP_ZERO=1
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_out_last, a_busy;
    logic [63:0] a_in_value = '0;
    logic [4:0]  a_in_rd = '0;
    logic [31:0] a_out_instr;

    // DUT B: SKIP_ZERO=0
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_last, b_busy;
    logic [63:0] b_in_value = '0;
    logic [4:0]  b_in_rd = '0;
    logic [31:0] b_out_instr;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    imm_mov_sequencer dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_value(a_in_value), .in_rd(a_in_rd),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_instr(a_out_instr),
        .out_last(a_out_last), .busy(a_busy)
    );

    imm_mov_sequencer #(.SKIP_ZERO(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_value(b_in_value), .in_rd(b_in_rd),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr),
        .out_last(b_out_last), .busy(b_busy)
    );

    // Reference model: the list of words a constant must produce.
    function automatic void build_expected(input logic [63:0] v, input logic [4:0] r, input bit skip);
        logic [15:0] h;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            h = v[16*i +: 16];
            if (!skip || h != 16'h0)
                exp_q.push_back({(exp_q.size() == 0) ? MOVZ : MOVK, 2'(i), h, r});
        end
        if (exp_q.size() == 0) exp_q.push_back({MOVZ, 2'd0, 16'h0, r});
    endfunction

    task automatic send_a(input logic [63:0] v, input logic [4:0] r);
        int n = 0;
        while (!a_in_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (a_in_ready !== 1'b1) begin
            failures++; $display("FAIL send_timeout in_ready=%b required=1", a_in_ready);
        end
        a_in_valid = 1'b1; a_in_value = v; a_in_rd = r;
        @(negedge clk);
        a_in_valid = 1'b0;
        checks++;
        if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin
            failures++; $display("FAIL accept_state busy=%b in_ready=%b required busy=1 in_ready=0", a_busy, a_in_ready);
        end
    endtask

    // stall<0: random 0..2 stall cycles per word. poke: drive in_valid while stalled.
    task automatic recv_a(input int stall, input bit poke, input int max_words);
        int ns;
        int w;
        for (w = 0; w < exp_q.size() && w < max_words; w++) begin
            ns = (stall < 0) ? int'($urandom_range(2, 0)) : stall;
            for (int k = 0; k < ns; k++) begin
                a_out_ready = 1'b0;
                if (poke) begin
                    a_in_valid = 1'b1; a_in_value = {$urandom, $urandom}; a_in_rd = 5'($urandom);
                    checks++;
                    if (a_in_ready !== 1'b0) begin
                        failures++; $display("FAIL busy_in_ready in_ready=%b required=0", a_in_ready);
                    end
                end
                checks++;
                if (a_out_valid !== 1'b1 || a_out_instr !== exp_q[w]) begin
                    failures++;
                    $display("FAIL stall_hold w=%0d valid=%b instr=%h required valid=1 instr=%h", w, a_out_valid, a_out_instr, exp_q[w]);
                end
                @(negedge clk);
            end
            a_in_valid = 1'b0;
            checks++;
            if (a_out_valid !== 1'b1 || a_out_instr !== exp_q[w] || a_out_last !== (w == exp_q.size() - 1)) begin
                failures++;
                $display("FAIL word w=%0d valid=%b instr=%h last=%b required valid=1 instr=%h last=%b",
                         w, a_out_valid, a_out_instr, a_out_last, exp_q[w], (w == exp_q.size() - 1));
            end
            a_out_ready = 1'b1;
            @(negedge clk);
            a_out_ready = 1'b0;
        end
        if (w == exp_q.size()) begin
            checks++;
            if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
                failures++;
                $display("FAIL seq_end in_ready=%b valid=%b busy=%b required 1 0 0", a_in_ready, a_out_valid, a_busy);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_instr !== 32'h0 || a_out_last !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1 ||
            b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_values a: v=%b i=%h l=%b b=%b r=%b  b: v=%b r=%b b=%b", a_out_valid, a_out_instr,
                     a_out_last, a_busy, a_in_ready, b_out_valid, b_in_ready, b_busy);
        end
        @(negedge clk); rst = 1'b0; @(negedge clk);
    endtask

    task automatic test_zero();
        exp_q.delete(); exp_q.push_back(32'hD2800001);
        send_a(64'h0, 5'd1); recv_a(0, 1'b0, 4);
    endtask

    task automatic test_two_words();
        exp_q.delete(); exp_q.push_back(32'hD28ACF02); exp_q.push_back(32'hF2C24682);
        send_a(64'h0000_1234_0000_5678, 5'd2); recv_a(0, 1'b0, 4);
    endtask

    task automatic test_top_hw();
        exp_q.delete(); exp_q.push_back(32'hD2F579BF);
        send_a(64'hABCD_0000_0000_0000, 5'd31); recv_a(0, 1'b0, 4);
    endtask

    task automatic test_stall();
        build_expected(64'h1111_2222_3333_4444, 5'd7, 1'b1);
        checks++;
        if (exp_q.size() != 4) begin failures++; $display("FAIL model_size got=%0d required=4", exp_q.size()); end
        send_a(64'h1111_2222_3333_4444, 5'd7); recv_a(3, 1'b1, 4);
    endtask

    task automatic test_async_reset();
        build_expected(64'h1111_2222_3333_4444, 5'd9, 1'b1);
        send_a(64'h1111_2222_3333_4444, 5'd9); recv_a(1, 1'b0, 2);
        checks++;
        if (a_out_valid !== 1'b1 || a_busy !== 1'b1) begin
            failures++; $display("FAIL pre_reset valid=%b busy=%b required 1 1", a_out_valid, a_busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0 || a_out_last !== 1'b0 || a_out_instr !== 32'h0) begin
            failures++;
            $display("FAIL async_reset valid=%b in_ready=%b busy=%b last=%b instr=%h required 0 1 0 0 0",
                     a_out_valid, a_in_ready, a_busy, a_out_last, a_out_instr);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        build_expected(64'h0000_0000_00FF_0000, 5'd4, 1'b1);
        send_a(64'h0000_0000_00FF_0000, 5'd4); recv_a(0, 1'b0, 4);
    endtask

    task automatic test_noskip();
        logic [31:0] lit [4];
        lit[0] = 32'hD28ACF03; lit[1] = 32'hF2A00003; lit[2] = 32'hF2C00003; lit[3] = 32'hF2E00003;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin
                b_in_value = 64'h5678; b_in_rd = 5'd3;
                exp_q.delete(); for (int i = 0; i < 4; i++) exp_q.push_back(lit[i]);
            end else begin
                b_in_value = {$urandom, $urandom} & 64'hFFFF_0000_FFFF_0000; b_in_rd = 5'($urandom);
                build_expected(b_in_value, b_in_rd, 1'b0);
            end
            b_in_valid = 1'b1;
            @(negedge clk);
            b_in_valid = 1'b0;
            b_out_ready = 1'b1;
            for (int w = 0; w < 4; w++) begin
                checks++;
                if (b_out_valid !== 1'b1 || b_out_instr !== exp_q[w] || b_out_last !== (w == 3)) begin
                    failures++;
                    $display("FAIL noskip t=%0d w=%0d valid=%b instr=%h last=%b required 1 %h %b",
                             t, w, b_out_valid, b_out_instr, b_out_last, exp_q[w], (w == 3));
                end
                @(negedge clk);
            end
            b_out_ready = 1'b0;
            checks++;
            if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
                failures++; $display("FAIL noskip_end in_ready=%b valid=%b required 1 0", b_in_ready, b_out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] v;
        logic [4:0]  r;
        for (int n = 0; n < 40; n++) begin
            v = {$urandom, $urandom};
            for (int i = 0; i < 4; i++) if ($urandom_range(1, 0) == 0) v[16*i +: 16] = 16'h0;
            r = 5'($urandom);
            build_expected(v, r, 1'b1);
            send_a(v, r);
            recv_a(-1, n[0], 4);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero();
        test_two_words();
        test_top_hw();
        test_stall();
        test_async_reset();
        test_noskip();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
